cpu_control_unit: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the CPU datapath. It owns the program counter and the instruction register, and fetches 16-bit instructions over a valid-handshake instruction-memory port. It decodes each instruction into the datapath control bundle (DA, AA, BA, FS, MB, resultSource, RW, MW, PC) and resolves branches and jumps using the register values the datapath returns.

---
 rtl/cpu_control_unit.sv | 153 +++++++++++++++
 tb/tb_cpu_control_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction sequencer: owns PC and IR, fetches 16-bit instructions,
// decodes the datapath control bundle and resolves branches and jumps.
module cpu_control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] imemData,
    input  logic        imemValid,
    input  logic [15:0] Dout,
    input  logic [15:0] Aout,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    output logic [3:0]  DA,
    output logic [3:0]  AA,
    output logic [3:0]  BA,
    output logic [2:0]  FS,
    output logic        MB,
    output logic [1:0]  resultSource,
    output logic        RW,
    output logic        MW,
    output logic [15:0] PC,
    output logic        instrDone
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        LOAD    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_LDI  = 4'b1001;
    localparam logic [3:0] OP_LD   = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1011;
    localparam logic [3:0] OP_BZ   = 4'b1100;
    localparam logic [3:0] OP_BNZ  = 4'b1101;
    localparam logic [3:0] OP_JR   = 4'b1110;
    localparam logic [3:0] OP_JAL  = 4'b1111;

    localparam logic [1:0] SRC_F   = 2'd0;
    localparam logic [1:0] SRC_PC  = 2'd1;
    localparam logic [1:0] SRC_RAM = 2'd2;
    localparam logic [1:0] SRC_IMM = 2'd3;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] ir_r, ir_s;
    logic [3:0]  opcode_s;
    logic [15:0] imm_s;
    logic [2:0]  fs_s;
    logic        mb_s;
    logic [1:0]  src_s;
    logic        writes_rd_s;
    logic        rw_s, mw_s, done_s;

    assign opcode_s = ir_r[15:12];
    assign imm_s    = {{8{ir_r[7]}}, ir_r[7:0]};

    // Field decode of the instruction register
    always_comb begin
        fs_s        = 3'b000;
        mb_s        = 1'b0;
        src_s       = SRC_F;
        writes_rd_s = 1'b0;
        case (opcode_s)
            OP_ADDI: begin mb_s = 1'b1; writes_rd_s = 1'b1; end
            OP_LDI:  begin src_s = SRC_IMM; writes_rd_s = 1'b1; end
            OP_LD:   src_s = SRC_RAM;
            OP_JAL:  begin src_s = SRC_PC; writes_rd_s = 1'b1; end
            OP_ST, OP_BZ, OP_BNZ, OP_JR: fs_s = 3'b000;
            default: begin
                fs_s        = opcode_s[2:0];
                writes_rd_s = 1'b1;
            end
        endcase
    end

    // Next-state, PC/IR update and strobe generation
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        rw_s    = 1'b0;
        mw_s    = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            FETCH: begin
                if (imemValid) begin
                    ir_s    = imemData;
                    pc_s    = pc_r + 16'd1;
                    state_s = DECODE;
                end else begin
                    state_s = FETCH;
                end
            end
            DECODE: state_s = EXECUTE;
            EXECUTE: begin
                rw_s = writes_rd_s;
                mw_s = (opcode_s == OP_ST);
                if (opcode_s == OP_LD) begin
                    state_s = LOAD;
                end else begin
                    state_s = FETCH;
                    done_s  = 1'b1;
                end
                // pc_r already points past this instruction, so it is the branch base
                case (opcode_s)
                    OP_BZ:   pc_s = (Dout == 16'h0000) ? pc_r + imm_s : pc_r;
                    OP_BNZ:  pc_s = (Dout != 16'h0000) ? pc_r + imm_s : pc_r;
                    OP_JR,
                    OP_JAL:  pc_s = Aout;
                    default: pc_s = pc_r;
                endcase
            end
            LOAD: begin
                rw_s    = 1'b1;
                done_s  = 1'b1;
                state_s = FETCH;
            end
            default: state_s = FETCH;
        endcase
    end

    // State, program counter and instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            ir_r    <= 16'h0000;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
        end
    end

    // Request is gated by reset so it stays low while reset is held
    assign imemReq      = (state_r == FETCH) && reset;
    assign imemAddr     = pc_r;
    assign PC           = pc_r;
    assign DA           = ir_r[11:8];
    assign AA           = ir_r[7:4];
    assign BA           = ir_r[3:0];
    assign FS           = fs_s;
    assign MB           = mb_s;
    assign resultSource = src_s;
    assign RW           = rw_s;
    assign MW           = mw_s;
    assign instrDone    = done_s;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit with hand-computed expectations.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic        imemValid = 1'b0;
    logic [15:0] Dout = 16'h0000;
    logic [15:0] Aout = 16'h0000;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [3:0]  DA, AA, BA;
    logic [2:0]  FS;
    logic        MB;
    logic [1:0]  resultSource;
    logic        RW, MW;
    logic [15:0] PC;
    logic        instrDone;

    int checks = 0;
    int errors = 0;

    cpu_control_unit #(.RESET_PC(16'h0010)) dut (
        .clk(clk), .reset(reset), .imemData(imemData), .imemValid(imemValid),
        .Dout(Dout), .Aout(Aout), .imemReq(imemReq), .imemAddr(imemAddr),
        .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .resultSource(resultSource),
        .RW(RW), .MW(MW), .PC(PC), .instrDone(instrDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic req, input logic rw,
                           input logic mw, input logic done, input logic [15:0] pc);
        check({tag, ".req"},  {31'd0, imemReq},   {31'd0, req});
        check({tag, ".rw"},   {31'd0, RW},        {31'd0, rw});
        check({tag, ".mw"},   {31'd0, MW},        {31'd0, mw});
        check({tag, ".done"}, {31'd0, instrDone}, {31'd0, done});
        check({tag, ".pc"},   {16'd0, PC},        {16'd0, pc});
    endtask

    // FETCH (valid same cycle), DECODE, EXECUTE, then the next FETCH cycle
    task automatic run3(input string tag, input logic [15:0] instr, input logic [15:0] fpc,
                        input logic erw, input logic emw, input logic [1:0] esrc,
                        input logic emb, input logic [2:0] efs, input logic [15:0] epc);
        logic [15:0] npc;
        npc       = fpc + 16'd1;
        imemData  = instr;
        imemValid = 1'b1;
        #1;
        strobes({tag, ".fetch"}, 1'b1, 1'b0, 1'b0, 1'b0, fpc);
        check({tag, ".addr"}, {16'd0, imemAddr}, {16'd0, fpc});
        tick();
        imemData = 16'hFFFF;
        #1;
        strobes({tag, ".dec"}, 1'b0, 1'b0, 1'b0, 1'b0, npc);
        tick();
        strobes({tag, ".ex"}, 1'b0, erw, emw, 1'b1, npc);
        check({tag, ".src"}, {30'd0, resultSource}, {30'd0, esrc});
        check({tag, ".mb"},  {31'd0, MB}, {31'd0, emb});
        check({tag, ".fs"},  {29'd0, FS}, {29'd0, efs});
        check({tag, ".da"},  {28'd0, DA}, {28'd0, instr[11:8]});
        tick();
        strobes({tag, ".next"}, 1'b1, 1'b0, 1'b0, 1'b0, epc);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
        check("rst.fields", {16'd0, DA, AA, BA, FS, MB}, 32'd0);
        check("rst.src", {30'd0, resultSource}, 32'd0);
        reset = 1'b1;

        run3("alu", 16'h0123, 16'h0010, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0011);

        // LD with imemValid held off for two cycles
        imemValid = 1'b0;
        imemData  = 16'hA450;
        #1;
        strobes("ld.f1", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
        tick();
        strobes("ld.f2", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
        tick();
        strobes("ld.f3", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
        imemValid = 1'b1;
        tick();
        imemData = 16'hFFFF;
        #1;
        strobes("ld.dec", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012);
        check("ld.dec.src", {30'd0, resultSource}, 32'd2);
        tick();
        strobes("ld.ex", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012);
        check("ld.ex.da", {24'd0, DA, AA}, 32'h45);
        tick();
        strobes("ld.load", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0012);
        check("ld.load.src", {30'd0, resultSource}, 32'd2);
        tick();
        strobes("ld.next", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012);

        Aout = 16'h0020;
        run3("jr20", 16'hE000, 16'h0012, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0020);
        Dout = 16'h0000;
        run3("bz_t", 16'hC1FE, 16'h0020, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h001F);
        run3("jr20b", 16'hE000, 16'h001F, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0020);
        Dout = 16'h0005;
        run3("bz_nt", 16'hC1FE, 16'h0020, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0021);
        run3("bnz_t", 16'hD1FE, 16'h0021, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0020);
        Aout = 16'hFFFF;
        run3("jrff", 16'hE000, 16'h0020, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'hFFFF);
        Dout = 16'h0000;
        run3("bz_wrap", 16'hC101, 16'hFFFF, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0001);
        Aout = 16'h0030;
        run3("jr30", 16'hE000, 16'h0001, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0030);
        Aout = 16'h0400;
        run3("jal", 16'hF700, 16'h0030, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0400);
        run3("ldi", 16'h9512, 16'h0400, 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0401);
        run3("st", 16'hB230, 16'h0401, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 16'h0402);
        run3("addi", 16'h8345, 16'h0402, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0, 16'h0403);
        run3("alu5", 16'h5AB4, 16'h0403, 1'b1, 1'b0, 2'd0, 1'b0, 3'd5, 16'h0404);

        // reset asserted during DECODE of an ALU instruction
        imemData = 16'h0123;
        #1;
        tick();
        strobes("ab.dec", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0405);
        reset = 1'b0;
        #1;
        strobes("ab.rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
        check("ab.fields", {16'd0, DA, AA, BA, FS, MB}, 32'd0);
        tick();
        strobes("ab.hold", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
        reset = 1'b1;
        #1;
        strobes("ab.rel", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
